pipelined_ram: RTL and testbench

PIPELINED_RAM -- requirements
Module: pipelined_ram

---
 rtl/pipelined_ram_if.sv | 35 +++
 rtl/pipelined_ram.sv | 154 +++++++++++++++
 tb/tb_pipelined_ram.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_ram_if.sv
// Dual-port RAM bus: a read-only fetch port (p1) and a load/store port (p2).
// The master drives requests; the slave returns responses.
interface pipelined_ram_if;
    logic        p1_req;
    logic [31:0] p1_addr;
    logic        p1_rvalid;
    logic [31:0] p1_rdata;
    logic        p1_err;

    logic        p2_req;
    logic        p2_we;
    logic [31:0] p2_addr;
    logic [1:0]  p2_size;
    logic        p2_unsigned;
    logic [31:0] p2_wdata;
    logic        p2_rvalid;
    logic [31:0] p2_rdata;
    logic        p2_err;

    modport master (
        output p1_req, p1_addr,
        output p2_req, p2_we, p2_addr, p2_size,
        output p2_unsigned, p2_wdata,
        input  p1_rvalid, p1_rdata, p1_err,
        input  p2_rvalid, p2_rdata, p2_err
    );

    modport slave (
        input  p1_req, p1_addr,
        input  p2_req, p2_we, p2_addr, p2_size,
        input  p2_unsigned, p2_wdata,
        output p1_rvalid, p1_rdata, p1_err,
        output p2_rvalid, p2_rdata, p2_err
    );
endinterface

// File: rtl/pipelined_ram.sv
// Dual-port byte-addressable RAM with a fixed-latency read pipeline.
// Memory is sampled at acceptance; writes land at the accepting edge.
module pipelined_ram #(
    parameter int unsigned MEM_SIZE   = 4096,
    parameter int unsigned START_ADDR = 0,
    parameter int unsigned LATENCY    = 1
) (
    input logic            clk,
    input logic            rst_n,
    pipelined_ram_if.slave bus
);
    localparam int unsigned NW = MEM_SIZE / 4;
    localparam int unsigned IW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [32:0] LO  = {1'b0, 32'(START_ADDR)};
    localparam logic [32:0] LIM = 33'(MEM_SIZE);

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [1:0]  off;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] data;
    } stage_t;

    logic [31:0] mem [NW];

    stage_t p1_st [LATENCY];
    stage_t p2_st [LATENCY];
    stage_t p1_nxt;
    stage_t p2_nxt;

    logic [32:0]   p1_off;
    logic          p1_bad;
    logic [IW-1:0] p1_idx;

    logic [32:0]   p2_off;
    logic [2:0]    p2_nb;
    logic          p2_bad;
    logic [IW-1:0] p2_idx;
    logic          p2_rd;
    logic          p2_wr;
    logic [3:0]    p2_be;
    logic [31:0]   p2_wdat;

    // Offset is computed in 33 bits so the end of an access never wraps.
    function automatic logic fits(
        input logic [32:0] off,
        input logic [2:0]  nb
    );
        logic [32:0] last;
        last = {1'b0, off[31:0]} + {30'd0, nb} - 33'd1;
        return !off[32] && (last < LIM);
    endfunction

    // Select the addressed lanes and extend them to 32 bits.
    function automatic logic [31:0] extract(input stage_t s);
        logic [31:0] sh;
        logic [31:0] r;
        sh = s.data >> {s.off, 3'b000};
        case (s.size)
            2'b00:   r = s.uns ? {24'd0, sh[7:0]}
                               : {{24{sh[7]}}, sh[7:0]};
            2'b01:   r = s.uns ? {16'd0, sh[15:0]}
                               : {{16{sh[15]}}, sh[15:0]};
            default: r = sh;
        endcase
        return s.valid ? r : 32'd0;
    endfunction

    // Port 1 decode: aligned word fetch, sampled into stage 0.
    always_comb begin
        p1_off = {1'b0, bus.p1_addr} - LO;
        p1_bad = (bus.p1_addr[1:0] != 2'b00) || !fits(p1_off, 3'd4);
        p1_idx = p1_off[IW+1:2];
        p1_nxt       = '0;
        p1_nxt.valid = bus.p1_req;
        p1_nxt.err   = bus.p1_req && p1_bad;
        p1_nxt.size  = 2'b10;
        p1_nxt.uns   = 1'b1;
        if (bus.p1_req && !p1_bad)
            p1_nxt.data = mem[p1_idx];
    end

    // Port 2 decode: fault checks, write lanes and the read sample.
    always_comb begin
        case (bus.p2_size)
            2'b00:   p2_nb = 3'd1;
            2'b01:   p2_nb = 3'd2;
            default: p2_nb = 3'd4;
        endcase
        p2_off = {1'b0, bus.p2_addr} - LO;
        p2_bad = (bus.p2_size == 2'b11)
              || (bus.p2_size == 2'b01 && bus.p2_addr[0])
              || (bus.p2_size == 2'b10 && bus.p2_addr[1:0] != 2'b00)
              || !fits(p2_off, p2_nb);
        p2_idx = p2_off[IW+1:2];
        p2_rd  = bus.p2_req && !bus.p2_we && !p2_bad;
        p2_wr  = bus.p2_req && bus.p2_we && !p2_bad;
        case (bus.p2_size)
            2'b00:   p2_be = 4'b0001 << bus.p2_addr[1:0];
            2'b01:   p2_be = 4'b0011 << bus.p2_addr[1:0];
            default: p2_be = 4'b1111;
        endcase
        p2_wdat = bus.p2_wdata << {bus.p2_addr[1:0], 3'b000};
        p2_nxt       = '0;
        p2_nxt.valid = bus.p2_req;
        p2_nxt.err   = bus.p2_req && p2_bad;
        p2_nxt.off   = bus.p2_addr[1:0];
        p2_nxt.size  = p2_rd ? bus.p2_size : 2'b10;
        p2_nxt.uns   = bus.p2_unsigned;
        if (p2_rd)
            p2_nxt.data = mem[p2_idx];
    end

    // Byte-lane writes; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (p2_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (p2_be[b])
                    mem[p2_idx][8*b +: 8] <= p2_wdat[8*b +: 8];
            end
        end
    end

    // Response pipelines; reset discards everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(LATENCY); i++) begin
                p1_st[i] <= '0;
                p2_st[i] <= '0;
            end
        end else begin
            p1_st[0] <= p1_nxt;
            p2_st[0] <= p2_nxt;
            for (int i = 1; i < int'(LATENCY); i++) begin
                p1_st[i] <= p1_st[i-1];
                p2_st[i] <= p2_st[i-1];
            end
        end
    end

    // Drive responses from the last stage.
    always_comb begin
        bus.p1_rvalid = p1_st[LATENCY-1].valid;
        bus.p1_err    = p1_st[LATENCY-1].valid
                     && p1_st[LATENCY-1].err;
        bus.p1_rdata  = extract(p1_st[LATENCY-1]);
        bus.p2_rvalid = p2_st[LATENCY-1].valid;
        bus.p2_err    = p2_st[LATENCY-1].valid
                     && p2_st[LATENCY-1].err;
        bus.p2_rdata  = extract(p2_st[LATENCY-1]);
    end
endmodule

// File: tb/tb_pipelined_ram.sv
// Directed bench for pipelined_ram at latencies 1, 3 and 4.
// Inputs change on the falling edge; outputs are checked there too.
module tb_pipelined_ram;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipelined_ram_if b1 ();
    pipelined_ram_if b3 ();
    pipelined_ram_if b4 ();

    pipelined_ram #(
        .MEM_SIZE(4096), .START_ADDR(32'h1000), .LATENCY(1)
    ) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    pipelined_ram #(
        .MEM_SIZE(4096), .START_ADDR(32'h1000), .LATENCY(3)
    ) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    pipelined_ram #(
        .MEM_SIZE(64), .START_ADDR(0), .LATENCY(4)
    ) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));

    task automatic idle();
        b1.p1_req = 0; b1.p1_addr = 0;
        b1.p2_req = 0; b1.p2_we = 0; b1.p2_addr = 0;
        b1.p2_size = 0; b1.p2_unsigned = 0; b1.p2_wdata = 0;
        b3.p1_req = 0; b3.p1_addr = 0;
        b3.p2_req = 0; b3.p2_we = 0; b3.p2_addr = 0;
        b3.p2_size = 0; b3.p2_unsigned = 0; b3.p2_wdata = 0;
        b4.p1_req = 0; b4.p1_addr = 0;
        b4.p2_req = 0; b4.p2_we = 0; b4.p2_addr = 0;
        b4.p2_size = 0; b4.p2_unsigned = 0; b4.p2_wdata = 0;
    endtask

    task automatic test_reset();
        logic [33:0] got [6];
        idle();
        rst_n = 0;
        b1.p1_req = 1; b1.p1_addr = 32'h1000;
        b4.p2_req = 1; b4.p2_size = 2'b10;
        repeat (3) @(negedge clk);
        got[0] = {b1.p1_rvalid, b1.p1_err, b1.p1_rdata};
        got[1] = {b1.p2_rvalid, b1.p2_err, b1.p2_rdata};
        got[2] = {b3.p1_rvalid, b3.p1_err, b3.p1_rdata};
        got[3] = {b3.p2_rvalid, b3.p2_err, b3.p2_rdata};
        got[4] = {b4.p1_rvalid, b4.p1_err, b4.p1_rdata};
        got[5] = {b4.p2_rvalid, b4.p2_err, b4.p2_rdata};
        for (int i = 0; i < 6; i++) begin
            n_chk++;
            if (got[i] !== 34'd0) begin
                n_fail++;
                $display("FAIL reset_out%0d: got %h expected 0",
                         i, got[i]);
            end
        end
        idle();
        rst_n = 1;
    endtask

    task automatic test_write_read();
        logic [33:0] g1, g2;
        b1.p2_req = 1; b1.p2_we = 1; b1.p2_addr = 32'h1000;
        b1.p2_size = 2'b10; b1.p2_wdata = 32'hDEADBEEF;
        @(negedge clk);
        g2 = {b1.p2_rvalid, b1.p2_err, b1.p2_rdata};
        n_chk++;
        if (g2 !== {2'b10, 32'd0}) begin
            n_fail++;
            $display("FAIL wr_ack: got %h expected %h",
                     g2, {2'b10, 32'd0});
        end
        b1.p2_we = 0; b1.p2_wdata = 0;
        b1.p1_req = 1; b1.p1_addr = 32'h1000;
        @(negedge clk);
        g1 = {b1.p1_rvalid, b1.p1_err, b1.p1_rdata};
        g2 = {b1.p2_rvalid, b1.p2_err, b1.p2_rdata};
        n_chk++;
        if (g1 !== {2'b10, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL rd_p1: got %h expected %h",
                     g1, {2'b10, 32'hDEADBEEF});
        end
        n_chk++;
        if (g2 !== {2'b10, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL rd_p2: got %h expected %h",
                     g2, {2'b10, 32'hDEADBEEF});
        end
        idle();
        @(negedge clk);
        g1 = {b1.p1_rvalid, b1.p1_err, b1.p1_rdata};
        g2 = {b1.p2_rvalid, b1.p2_err, b1.p2_rdata};
        n_chk++;
        if ({g1, g2} !== 68'd0) begin
            n_fail++;
            $display("FAIL idle_out: got %h %h expected 0", g1, g2);
        end
    endtask

    task automatic test_extend();
        logic [31:0] ta [6] = '{32'h1003, 32'h1003, 32'h1002,
                                32'h1000, 32'h1000, 32'h1001};
        logic [1:0]  ts [6] = '{0, 0, 1, 1, 0, 0};
        logic        tu [6] = '{0, 1, 0, 1, 0, 1};
        logic [31:0] te [6] = '{32'hFFFFFFDE, 32'h000000DE,
                                32'hFFFFDEAD, 32'h0000BEEF,
                                32'hFFFFFFEF, 32'h000000BE};
        logic [33:0] g;
        for (int i = 0; i < 6; i++) begin
            b1.p2_req = 1; b1.p2_we = 0; b1.p2_addr = ta[i];
            b1.p2_size = ts[i]; b1.p2_unsigned = tu[i];
            @(negedge clk);
            g = {b1.p2_rvalid, b1.p2_err, b1.p2_rdata};
            n_chk++;
            if (g !== {2'b10, te[i]}) begin
                n_fail++;
                $display("FAIL ext%0d: got %h expected %h",
                         i, g, {2'b10, te[i]});
            end
        end
        b1.p2_we = 1; b1.p2_addr = 32'h1001;
        b1.p2_size = 2'b00; b1.p2_wdata = 32'hAAAAAA55;
        @(negedge clk);
        b1.p2_addr = 32'h1002;
        b1.p2_size = 2'b01; b1.p2_wdata = 32'hFFFF1234;
        @(negedge clk);
        g = {b1.p2_rvalid, b1.p2_err, b1.p2_rdata};
        n_chk++;
        if (g !== {2'b10, 32'd0}) begin
            n_fail++;
            $display("FAIL half_wr_ack: got %h expected %h",
                     g, {2'b10, 32'd0});
        end
        idle();
        b1.p1_req = 1; b1.p1_addr = 32'h1000;
        @(negedge clk);
        g = {b1.p1_rvalid, b1.p1_err, b1.p1_rdata};
        n_chk++;
        if (g !== {2'b10, 32'h123455EF}) begin
            n_fail++;
            $display("FAIL lane_wr: got %h expected %h",
                     g, {2'b10, 32'h123455EF});
        end
        idle();
        @(negedge clk);
    endtask

    task automatic test_range();
        logic        we [10] = '{1, 0, 0, 1, 0, 1, 0, 1, 0, 0};
        logic [31:0] ad [10] = '{32'h3C, 32'h3E, 32'h3F, 32'h40,
                                 32'h00, 32'h3E, 32'hFFFFFFFE,
                                 32'h3F, 32'h3C, 32'h3F};
        logic [1:0]  sz [10] = '{2, 2, 1, 2, 3, 2, 2, 1, 2, 0};
        logic [31:0] wd [10] = '{32'h11223344, 0, 0, 32'hBADBAD00,
                                 0, 32'h99999999, 0, 32'h7777, 0, 0};
        logic [33:0] e2 [10] = '{{2'b10, 32'd0}, {2'b11, 32'd0},
                                 {2'b11, 32'd0}, {2'b11, 32'd0},
                                 {2'b11, 32'd0}, {2'b11, 32'd0},
                                 {2'b11, 32'd0}, {2'b11, 32'd0},
                                 {2'b10, 32'h11223344},
                                 {2'b10, 32'h00000011}};
        logic        pe [10] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 0};
        logic [31:0] pa [10] = '{32'h3E, 32'h40, 32'hFFFFFFFC, 32'h02,
                                 0, 0, 0, 0, 32'h3C, 0};
        logic [33:0] e1 [10] = '{{2'b11, 32'd0}, {2'b11, 32'd0},
                                 {2'b11, 32'd0}, {2'b11, 32'd0},
                                 34'd0, 34'd0, 34'd0, 34'd0,
                                 {2'b10, 32'h11223344}, 34'd0};
        logic [33:0] g1, g2;
        for (int i = 0; i < 10; i++) begin
            b4.p2_req = 1; b4.p2_we = we[i]; b4.p2_addr = ad[i];
            b4.p2_size = sz[i]; b4.p2_unsigned = 1;
            b4.p2_wdata = wd[i];
            b4.p1_req = pe[i]; b4.p1_addr = pa[i];
            @(negedge clk);
            idle();
            repeat (2) @(negedge clk);
            g1 = {b4.p1_rvalid, b4.p1_err, b4.p1_rdata};
            g2 = {b4.p2_rvalid, b4.p2_err, b4.p2_rdata};
            n_chk++;
            if ({g1, g2} !== 68'd0) begin
                n_fail++;
                $display("FAIL early%0d: got %h %h expected 0",
                         i, g1, g2);
            end
            @(negedge clk);
            g1 = {b4.p1_rvalid, b4.p1_err, b4.p1_rdata};
            g2 = {b4.p2_rvalid, b4.p2_err, b4.p2_rdata};
            n_chk++;
            if (g2 !== e2[i]) begin
                n_fail++;
                $display("FAIL range_p2_%0d: got %h expected %h",
                         i, g2, e2[i]);
            end
            n_chk++;
            if (g1 !== e1[i]) begin
                n_fail++;
                $display("FAIL range_p1_%0d: got %h expected %h",
                         i, g1, e1[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [33:0] g;
        for (int t = 0; t < 8; t++) begin
            idle();
            if (t < 4) begin
                b3.p2_req = 1; b3.p2_we = 1; b3.p2_size = 2'b10;
                b3.p2_addr = 32'h1000 + 32'(4 * t);
                b3.p2_wdata = 32'hA0000000 + 32'(t);
            end
            @(negedge clk);
            g = {b3.p2_rvalid, b3.p2_err, b3.p2_rdata};
            n_chk++;
            if (g !== ((t >= 2 && t <= 5) ? {2'b10, 32'd0} : 34'd0)) begin
                n_fail++;
                $display("FAIL b2b_wr%0d: got %h", t + 1, g);
            end
        end
        for (int t = 0; t < 8; t++) begin
            idle();
            if (t < 4) begin
                b3.p1_req = 1;
                b3.p1_addr = 32'h1000 + 32'(4 * t);
                b3.p2_req = 1; b3.p2_size = 2'b10;
                b3.p2_addr = 32'h100C - 32'(4 * t);
            end
            @(negedge clk);
            g = {b3.p1_rvalid, b3.p1_err, b3.p1_rdata};
            n_chk++;
            if (t >= 2 && t <= 5) begin
                if (g !== {2'b10, 32'hA0000000 + 32'(t - 2)}) begin
                    n_fail++;
                    $display("FAIL b2b_p1_%0d: got %h expected %h",
                             t + 1, g,
                             {2'b10, 32'hA0000000 + 32'(t - 2)});
                end
            end else if (g !== 34'd0) begin
                n_fail++;
                $display("FAIL b2b_p1_%0d: got %h expected 0",
                         t + 1, g);
            end
            g = {b3.p2_rvalid, b3.p2_err, b3.p2_rdata};
            n_chk++;
            if (t >= 2 && t <= 5) begin
                if (g !== {2'b10, 32'hA0000000 + 32'(5 - t)}) begin
                    n_fail++;
                    $display("FAIL b2b_p2_%0d: got %h expected %h",
                             t + 1, g,
                             {2'b10, 32'hA0000000 + 32'(5 - t)});
                end
            end else if (g !== 34'd0) begin
                n_fail++;
                $display("FAIL b2b_p2_%0d: got %h expected 0",
                         t + 1, g);
            end
        end
    endtask

    task automatic test_same_edge();
        logic        r1 [8] = '{1, 1, 1, 0, 1, 0, 0, 0};
        logic [31:0] a1 [8] = '{32'h1000, 32'h1000, 32'h1004, 0,
                                32'h1004, 0, 0, 0};
        logic        r2 [8] = '{1, 1, 0, 1, 0, 0, 0, 0};
        logic        w2 [8] = '{1, 0, 0, 1, 0, 0, 0, 0};
        logic [31:0] a2 [8] = '{32'h1000, 32'h1000, 0, 32'h1004,
                                0, 0, 0, 0};
        logic [31:0] d2 [8] = '{32'h12345678, 0, 0, 32'h0BADF00D,
                                0, 0, 0, 0};
        logic [33:0] e1 [9] = '{34'd0, 34'd0, 34'd0,
                                {2'b10, 32'hA0000000},
                                {2'b10, 32'h12345678},
                                {2'b10, 32'hA0000001}, 34'd0,
                                {2'b10, 32'h0BADF00D}, 34'd0};
        logic [33:0] e2 [9] = '{34'd0, 34'd0, 34'd0,
                                {2'b10, 32'd0},
                                {2'b10, 32'h12345678}, 34'd0,
                                {2'b10, 32'd0}, 34'd0, 34'd0};
        logic [33:0] g1, g2;
        for (int c = 0; c < 8; c++) begin
            idle();
            b3.p1_req = r1[c]; b3.p1_addr = a1[c];
            b3.p2_req = r2[c]; b3.p2_we = w2[c];
            b3.p2_addr = a2[c]; b3.p2_wdata = d2[c];
            b3.p2_size = 2'b10;
            @(negedge clk);
            g1 = {b3.p1_rvalid, b3.p1_err, b3.p1_rdata};
            g2 = {b3.p2_rvalid, b3.p2_err, b3.p2_rdata};
            n_chk++;
            if (g1 !== e1[c+1]) begin
                n_fail++;
                $display("FAIL rbw_p1_%0d: got %h expected %h",
                         c + 1, g1, e1[c+1]);
            end
            n_chk++;
            if (g2 !== e2[c+1]) begin
                n_fail++;
                $display("FAIL rbw_p2_%0d: got %h expected %h",
                         c + 1, g2, e2[c+1]);
            end
        end
        idle();
    endtask

    task automatic test_reset_flush();
        logic [33:0] g1, g2;
        b4.p2_req = 1; b4.p2_we = 1; b4.p2_addr = 32'h10;
        b4.p2_size = 2'b10; b4.p2_wdata = 32'hCAFEF00D;
        @(negedge clk);
        idle();
        repeat (3) @(negedge clk);
        b4.p1_req = 1; b4.p1_addr = 32'h10;
        @(negedge clk);
        idle();
        b4.p2_req = 1; b4.p2_addr = 32'h10; b4.p2_size = 2'b10;
        @(negedge clk);
        idle();
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        g1 = {b4.p1_rvalid, b4.p1_err, b4.p1_rdata};
        g2 = {b4.p2_rvalid, b4.p2_err, b4.p2_rdata};
        n_chk++;
        if ({g1, g2} !== 68'd0) begin
            n_fail++;
            $display("FAIL in_reset: got %h %h expected 0", g1, g2);
        end
        #4 rst_n = 1;
        b4.p1_req = 1; b4.p1_addr = 32'h10;
        b4.p2_req = 1; b4.p2_addr = 32'h3C; b4.p2_size = 2'b10;
        for (int t = 1; t <= 4; t++) begin
            @(negedge clk);
            idle();
            g1 = {b4.p1_rvalid, b4.p1_err, b4.p1_rdata};
            g2 = {b4.p2_rvalid, b4.p2_err, b4.p2_rdata};
            n_chk++;
            if (t < 4 && {g1, g2} !== 68'd0) begin
                n_fail++;
                $display("FAIL flush%0d: got %h %h expected 0",
                         t, g1, g2);
            end else if (t == 4 &&
                         {g1, g2} !== {2'b10, 32'hCAFEF00D,
                                       2'b10, 32'h11223344}) begin
                n_fail++;
                $display("FAIL post_rst: got %h %h expected %h %h",
                         g1, g2, {2'b10, 32'hCAFEF00D},
                         {2'b10, 32'h11223344});
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_extend();
        test_range();
        test_back_to_back();
        test_same_edge();
        test_reset_flush();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
